// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the bit-stream framing blocks.
package bitstream_pkg;

    // Packer state: waiting for a start-of-packet, or inside a packet.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    // Widest word any stage in this family produces, and its empty field.
    localparam int WORD_MAX_W  = 64;
    localparam int EMPTY_MAX_W = 7;

    // Width of the empty field for a word of the given width.
    function automatic int ew_of(input int width);
        return $clog2(width) + 1;
    endfunction

    // One framed output word, sized for the widest configuration.
    typedef struct packed {
        logic [WORD_MAX_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_MAX_W-1:0] empty;
    } word_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register with ready latency 0.
// Loads when empty or when the held entry drains on the same edge.
module stream_out_reg #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          valid_r;
    logic [PW-1:0] data_r;

    // Space is available when nothing is held or the held entry leaves now.
    always_comb begin
        in_ready = !valid_r || out_ready;
    end

    // Holding register: load on free slot, otherwise keep contents stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {PW{1'b0}};
        end else if (srst) begin
            valid_r <= 1'b0;
            data_r  <= {PW{1'b0}};
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule

// File: rtl/bit_deserializer.sv
// Packs a framed 1-bit stream into WIDTH-bit words, MSB first, keeping
// packet framing and flagging sop violations.
module bit_deserializer
    import bitstream_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int EW    = ew_of(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic             i_sop,
    input  logic             i_eop,
    input  logic             inp,
    output logic             i_ready,
    input  logic             o_ready,
    output logic             o_valid,
    output logic             o_sop,
    output logic             o_eop,
    output logic [WIDTH-1:0] outp,
    output logic [EW-1:0]    o_empty,
    output logic             o_err
);

    // Counter must be able to hold WIDTH itself at the completing bit.
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = WIDTH + 2 + EW;

    pkt_state_e       state_r,  state_nxt_s;
    logic [CW-1:0]    count_r,  count_nxt_s;
    logic [WIDTH-1:0] acc_r,    acc_nxt_s;
    logic             first_r,  first_nxt_s;
    logic             err_r,    err_nxt_s;

    logic             out_in_ready_s;
    logic             accept_s;
    logic             take_s;
    logic             emit_s;
    logic [WIDTH-1:0] base_acc_s;
    logic [CW-1:0]    base_count_s;
    logic             base_first_s;
    logic [WIDTH-1:0] new_acc_s;
    logic [CW-1:0]    new_count_s;
    logic [CW-1:0]    shamt_s;
    logic [WIDTH-1:0] word_data_s;
    logic             word_sop_s;
    logic             word_eop_s;
    logic [EW-1:0]    word_empty_s;
    logic [PW-1:0]    pay_in_s;
    logic [PW-1:0]    pay_out_s;

    // Backpressure follows the output slot only, never the input bit itself.
    always_comb begin
        i_ready  = reset_n && out_in_ready_s;
        accept_s = i_valid && i_ready;
    end

    // Packer next state: start/continue/drop the bit and decide emission.
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        acc_nxt_s    = acc_r;
        first_nxt_s  = first_r;
        err_nxt_s    = 1'b0;
        emit_s       = 1'b0;
        take_s       = 1'b0;
        base_acc_s   = acc_r;
        base_count_s = count_r;
        base_first_s = first_r;
        word_data_s  = {WIDTH{1'b0}};
        word_sop_s   = 1'b0;
        word_eop_s   = 1'b0;
        word_empty_s = {EW{1'b0}};

        if (accept_s) begin
            if (i_sop) begin
                // A sop inside a packet abandons the partial word.
                take_s       = 1'b1;
                base_acc_s   = {WIDTH{1'b0}};
                base_count_s = {CW{1'b0}};
                base_first_s = 1'b1;
                err_nxt_s    = (state_r == IN_PKT);
            end else if (state_r == IN_PKT) begin
                take_s = 1'b1;
            end else begin
                // Data outside a packet is dropped.
                err_nxt_s = 1'b1;
            end
        end else begin
            take_s = 1'b0;
        end

        new_acc_s   = {base_acc_s[WIDTH-2:0], inp};
        new_count_s = base_count_s + CW'(1);
        shamt_s     = CW'(WIDTH) - new_count_s;

        if (take_s) begin
            if ((new_count_s == CW'(WIDTH)) || i_eop) begin
                // Left-align the collected bits; unused LSBs are zero.
                emit_s       = 1'b1;
                word_data_s  = new_acc_s << shamt_s;
                word_sop_s   = base_first_s;
                word_eop_s   = i_eop;
                word_empty_s = EW'(shamt_s);
                acc_nxt_s    = {WIDTH{1'b0}};
                count_nxt_s  = {CW{1'b0}};
                first_nxt_s  = 1'b0;
                state_nxt_s  = i_eop ? IDLE : IN_PKT;
            end else begin
                acc_nxt_s   = new_acc_s;
                count_nxt_s = new_count_s;
                first_nxt_s = base_first_s;
                state_nxt_s = IN_PKT;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Packer state, counter, accumulator and error pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            first_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            acc_r   <= acc_nxt_s;
            first_r <= first_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign pay_in_s = {word_data_s, word_sop_s, word_eop_s, word_empty_s};

    stream_out_reg #(
        .PW (PW)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (reset_n),
        .srst      (1'b0),
        .in_valid  (emit_s),
        .in_ready  (out_in_ready_s),
        .in_data   (pay_in_s),
        .out_valid (o_valid),
        .out_ready (o_ready),
        .out_data  (pay_out_s)
    );

    assign {outp, o_sop, o_eop, o_empty} = pay_out_s;
    assign o_err = err_r;

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Sits directly downstream of bitdetector and consumes its 1-bit framed stream (outp, o_valid, o_sop, o_eop, with i_ready as backpressure).
- Packs the stream into WIDTH-bit words, MSB-first, and keeps the packet framing.
- Presents the words on a valid/ready streaming interface with ready latency 0. The interface is signal-compatible in style with bitdetector.
- Flags framing violations on the input stream.

Parameters:
- WIDTH, 8, output word width in bits; legal range 2..64.
- EW, $clog2(WIDTH)+1 (derived, not overridable), width of o_empty.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input bit valid.
- i_sop  input  1  first bit of packet; qualified by i_valid.
- i_eop  input  1  last bit of packet; qualified by i_valid.
- inp  input  1  serial data bit.
- i_ready  output  1  block can accept a bit this cycle.
- o_ready  input  1  downstream accepts the word this cycle.
- o_valid  output  1  output word valid.
- o_sop  output  1  first word of packet.
- o_eop  output  1  last word of packet.
- outp  output  WIDTH  packed word; the first received bit is at bit WIDTH-1.
- o_empty  output  EW  number of unused LSBs in the word; non-zero only with o_eop.
- o_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (reset_n low, asynchronous):
  - o_valid, o_sop, o_eop, outp, o_empty and o_err go to 0.
  - The bit counter and accumulator go to 0; the FSM goes to IDLE.
  - i_ready is forced to 0 while reset_n is low.
- Reset asserted mid-packet discards the partial word and any held output word. There is no o_eop for the aborted packet.
- Bit acceptance: a bit is accepted when i_valid && i_ready at a rising edge.
- Input ready: i_ready = reset_n && !(o_valid && !o_ready).
  - This is a combinational path from o_ready to i_ready, and it is permitted.
  - i_ready never depends on i_valid, i_sop, i_eop or inp.
- Output register: a single-entry register holding outp, o_sop, o_eop and o_empty.
  - The register is loaded only when it is empty or being drained in the same cycle.
  - The contents are held stable while o_valid && !o_ready.
- FSM state IDLE: waiting for the start of a packet.
  - Accepted bit with i_sop=1: enter IN_PKT. The bit is loaded as accumulator bit 0, count=1, and the word is marked as first-of-packet.
  - Accepted bit with i_sop=0: the bit is dropped and o_err pulses the next cycle.
- FSM state IN_PKT:
  - Accepted bit with i_sop=0: shift it in, acc = {acc[WIDTH-2:0], inp}, count+1.
  - Accepted bit with i_sop=1: the partial word is discarded and o_err pulses. The bit restarts a new packet exactly as in IDLE, including sop/eop handling.
- Word emission: a word is emitted when the accepted bit makes count reach WIDTH, or the accepted bit has i_eop=1.
  - The output register loads on the same edge, so o_valid rises the cycle after the completing bit is accepted. Latency from completing bit to o_valid is 1 cycle.
  - Full word: outp = {acc, inp}, o_empty = 0.
  - Partial word at eop with n bits: the bits are left-aligned, the low WIDTH-n bits are 0, and o_empty = WIDTH-n.
  - o_sop = 1 on the first word emitted after sop.
  - o_eop = 1 when the word was closed by i_eop.
  - After emission, count = 0. The FSM returns to IDLE if eop, otherwise it stays in IN_PKT.
- Single-bit packet (i_sop && i_eop on the same bit): one word with o_sop=o_eop=1, outp = inp<<(WIDTH-1), o_empty = WIDTH-1.
- An eop that coincides with count reaching WIDTH gives a full word with o_eop=1 and o_empty=0. No extra empty word is produced.
- Throughput: 1 bit per cycle sustained when o_ready is held high. Words are back-to-back at most every WIDTH cycles.
- Values of i_sop, i_eop and inp are ignored when i_valid=0.

Decomposition:
- Shared package bitstream_pkg:
  - typedef for the FSM state enum (IDLE, IN_PKT).
  - localparam helper function for EW.
  - struct for the output word: data, sop, eop, empty.
- One natural sub-module: stream_out_reg. It is the single-entry valid/ready output holding register, parameterised by payload width. bitdetector-adjacent stages reuse it.
- The packer FSM, counter and accumulator stay in bit_deserializer.

Test Plan (WIDTH=8):
- Contiguous 16-bit packet 0xA5 then 0x3C, MSB first, sop on bit 0, eop on bit 15, o_ready=1 -> word 0xA5 with o_sop=1, one cycle after bit 7; then word 0x3C with o_eop=1 and o_empty=0, one cycle after bit 15; o_err stays 0.
- 11-bit packet 10110011_101 -> word 0xB3 (sop); then word 0xA0 with o_eop=1 and o_empty=5.
- Single bit inp=1 with i_sop=i_eop=1 -> outp=0x80, o_sop=o_eop=1, o_empty=7.
- o_ready held low for 5 cycles while word 0xA5 is valid -> i_ready=0 throughout and outp stable. After release, the next 8 bits 0x3C arrive intact with no duplicate or lost word.
- Three bits with no sop, then a mid-packet sop after 4 bits -> o_err pulses 3 times for the dropped bits. At the second sop o_err pulses once, the 4 partial bits are discarded, and the new packet's first word carries o_sop=1.
- reset_n pulled low asynchronously after 5 bits of a packet -> all outputs 0 immediately and i_ready=0. After release, a fresh packet 0x5A gives exactly one word 0x5A with o_sop=o_eop=1 and o_empty=0.
